// File: rtl/tinyqv_nibble_alu_if.sv
// Nibble-slice bus between the register file side (master) and the nibble ALU (slave).
// en qualifies the nibble on counter/op/a_in/b_in; there is no ready, and the ALU accepts every nibble with en=1.
interface tinyqv_nibble_alu_if #(
   parameter int NIBBLES = 8
);
   localparam int CW = $clog2(NIBBLES);

   logic          en;
   logic [CW-1:0] counter;
   logic [2:0]    op;
   logic [3:0]    a_in;
   logic [3:0]    b_in;
   logic [3:0]    d_out;
   logic          cmp_out;
   logic          cmp_valid;

   modport master (
      output en, counter, op, a_in, b_in,
      input  d_out, cmp_out, cmp_valid
   );

   modport slave (
      input  en, counter, op, a_in, b_in,
      output d_out, cmp_out, cmp_valid
   );
endinterface

// File: rtl/tinyqv_nibble_alu.sv
// Nibble-serial ALU: one 4-bit slice of rs1/rs2 per cycle, LSB first, with carry and
// equality held across nibbles and a registered compare result after the last nibble.
module tinyqv_nibble_alu #(
   parameter int NIBBLES = 8
) (
   input logic               clk,
   input logic               rst,
   tinyqv_nibble_alu_if.slave bus
);
   localparam int            CW     = $clog2(NIBBLES);
   localparam logic [CW-1:0] LAST   = CW'(NIBBLES - 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_SLTU = 3'b110;
   localparam logic [2:0] OP_EQ   = 3'b111;

   logic       carry_q;
   logic       eq_q;
   logic [2:0] op_q;
   logic       cmp_q;
   logic       cmp_valid_q;

   logic       first;
   logic       last;
   logic [2:0] eff_op;
   logic       is_sub;
   logic       cin;
   logic [3:0] bx;
   logic [4:0] sum5;
   logic       nib_eq;
   logic       eq_base;
   logic [3:0] d_nib;
   logic       cmp_d;

   always_comb begin
      first   = (bus.counter == '0);
      last    = (bus.counter == LAST);
      // op is only trusted on nibble 0; later nibbles use the captured copy
      eff_op  = first ? bus.op : op_q;
      is_sub  = (eff_op == OP_SUB) || (eff_op == OP_SLT) ||
                (eff_op == OP_SLTU) || (eff_op == OP_EQ);
      bx      = is_sub ? ~bus.b_in : bus.b_in;
      cin     = first ? is_sub : carry_q;
      sum5    = {1'b0, bus.a_in} + {1'b0, bx} + {4'b0000, cin};
      nib_eq  = (bus.a_in == bus.b_in);
      eq_base = first ? 1'b1 : eq_q;

      d_nib = sum5[3:0];
      case (eff_op)
         OP_AND:  d_nib = bus.a_in & bus.b_in;
         OP_OR:   d_nib = bus.a_in | bus.b_in;
         OP_XOR:  d_nib = bus.a_in ^ bus.b_in;
         default: d_nib = sum5[3:0];
      endcase

      cmp_d = 1'b0;
      case (eff_op)
         OP_SLT:  cmp_d = (bus.a_in[3] ^ bus.b_in[3]) ? bus.a_in[3] : sum5[3];
         OP_SLTU: cmp_d = ~sum5[4];
         OP_EQ:   cmp_d = eq_base & nib_eq;
         default: cmp_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_q     <= 1'b0;
         eq_q        <= 1'b1;
         op_q        <= OP_ADD;
         cmp_q       <= 1'b0;
         cmp_valid_q <= 1'b0;
      end else if (bus.en) begin
         carry_q     <= sum5[4];
         eq_q        <= eq_base & nib_eq;
         cmp_valid_q <= last;
         if (first) op_q  <= bus.op;
         if (last)  cmp_q <= cmp_d;
      end else begin
         cmp_valid_q <= 1'b0;
      end
   end

   assign bus.d_out     = d_nib;
   assign bus.cmp_out   = cmp_q;
   assign bus.cmp_valid = cmp_valid_q;
endmodule

// File: tb/tb_tinyqv_nibble_alu.sv
// Directed bench for tinyqv_nibble_alu: whole words driven nibble by nibble, results
// reassembled and compared against hand-computed words and compare bits.
module tb_tinyqv_nibble_alu;
   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;
   logic [31:0] exp_q[$];

   tinyqv_nibble_alu_if #(.NIBBLES(8)) bus ();

   tinyqv_nibble_alu #(.NIBBLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // stall_after < 0 disables the en-low gap; flip_op changes op on nibbles 1..7
   task automatic run_word(input string tag, input logic [2:0] w_op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_cmp,
                           input int stall_after, input int stall_len, input bit flip_op);
      logic [31:0] got;
      logic [31:0] want;
      got = '0;
      exp_q.push_back(exp_d);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.en      = 1'b1;
         bus.counter = 3'(i);
         bus.op      = (flip_op && i > 0) ? (w_op ^ 3'b100) : w_op;
         bus.a_in    = a[4*i +: 4];
         bus.b_in    = b[4*i +: 4];
         #1 got[4*i +: 4] = bus.d_out;
         if (i == stall_after) begin
            for (int s = 0; s < stall_len; s++) begin
               @(negedge clk);
               bus.en   = 1'b0;
               bus.a_in = 4'($urandom_range(0, 15));
               bus.b_in = 4'($urandom_range(0, 15));
               #1 check({tag, " stall_valid"}, {31'b0, bus.cmp_valid}, 32'd0);
            end
         end
      end
      @(negedge clk);
      bus.en      = 1'b0;
      bus.counter = 3'd0;
      #1;
      check({tag, " valid"}, {31'b0, bus.cmp_valid}, 32'd1);
      check({tag, " cmp"},   {31'b0, bus.cmp_out},   {31'b0, exp_cmp});
      want = exp_q.pop_front();
      check({tag, " d"}, got, want);
      @(negedge clk);
      #1 check({tag, " valid_drop"}, {31'b0, bus.cmp_valid}, 32'd0);
   endtask

   task automatic abort_word();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.en      = 1'b1;
         bus.counter = 3'(i);
         bus.op      = 3'b110;
         bus.a_in    = 4'h0;
         bus.b_in    = (i == 0) ? 4'h1 : 4'h0;
      end
      #1 rst = 1'b1;
      #1;
      check("rst_cmp",   {31'b0, bus.cmp_out},   32'd0);
      check("rst_valid", {31'b0, bus.cmp_valid}, 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      bus.en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 check("post_rst_valid", {31'b0, bus.cmp_valid}, 32'd0);
      end
   endtask

   initial begin
      n_total     = 0;
      n_bad       = 0;
      rst         = 1'b1;
      bus.en      = 1'b0;
      bus.counter = 3'd1;
      bus.op      = 3'b001;
      bus.a_in    = 4'h3;
      bus.b_in    = 4'h4;
      #2;
      // mid-word nibble in reset uses op_q=ADD with carry 0: 3+4
      check("reset_d",     {28'b0, bus.d_out},     32'd7);
      check("reset_cmp",   {31'b0, bus.cmp_out},   32'd0);
      check("reset_valid", {31'b0, bus.cmp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_word("add_f_1",   3'b000, 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0, -1, 0, 1'b1);
      run_word("sub_0_1",   3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, -1, 0, 1'b0);
      run_word("sltu_0_1",  3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, -1, 0, 1'b0);
      run_word("slt_neg",   3'b101, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, -1, 0, 1'b0);
      run_word("slt_pos",   3'b101, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, -1, 0, 1'b0);
      run_word("eq_same",   3'b111, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, -1, 0, 1'b0);
      run_word("eq_lsb",    3'b111, 32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 1'b0, -1, 0, 1'b0);
      run_word("eq_msb",    3'b111, 32'h1234_5678, 32'h9234_5678, 32'h8000_0000, 1'b0, -1, 0, 1'b0);
      run_word("and",       3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, -1, 0, 1'b0);
      run_word("or",        3'b011, 32'h1200_00F0, 32'h0034_0F00, 32'h1234_0FF0, 1'b0, -1, 0, 1'b0);
      run_word("xor",       3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, -1, 0, 1'b0);
      run_word("add_stall", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 3, 3, 1'b0);
      run_word("sltu_pre",  3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, -1, 0, 1'b0);
      abort_word();
      run_word("add_2_3",   3'b000, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, -1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
